// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Counter width helper that never returns zero, so 1-valued ranges still get a bit.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, circularly.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] pick_idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter with round-robin cycle grants,
// outstanding-request limiting and a watchdog that aborts hung cycles with ERR.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     wbm_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     wbm_dat_m,
  output logic [DATA_WIDTH-1:0]                 wbm_dat_s,
  input  logic [NUM_MASTERS-1:0]                wbm_we,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] wbm_sel,
  input  logic [NUM_MASTERS-1:0]                wbm_stb,
  input  logic [NUM_MASTERS-1:0]                wbm_cyc,
  output logic [NUM_MASTERS-1:0]                wbm_ack,
  output logic [NUM_MASTERS-1:0]                wbm_err,
  output logic [NUM_MASTERS-1:0]                wbm_stall,
  output logic [ADDR_WIDTH-1:0]                 wbs_adr,
  output logic [DATA_WIDTH-1:0]                 wbs_dat_m,
  input  logic [DATA_WIDTH-1:0]                 wbs_dat_s,
  output logic                                  wbs_we,
  output logic [DATA_WIDTH/8-1:0]               wbs_sel,
  output logic                                  wbs_stb,
  output logic                                  wbs_cyc,
  input  logic                                  wbs_ack,
  input  logic                                  wbs_err,
  input  logic                                  wbs_stall,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  timeout
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int IW   = $clog2(NUM_MASTERS);
  localparam int OW   = clog2_min1(MAX_OUTSTANDING + 1);
  localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);

  arb_state_t             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [IW-1:0]          gidx_reg, gidx_next;
  logic [IW-1:0]          ptr_reg, ptr_next;
  logic [OW-1:0]          outst_reg, outst_next;
  logic [WD_W-1:0]        wdog_reg, wdog_next;
  logic                   abort_first_reg, abort_first_next;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req      (wbm_cyc),
    .ptr      (ptr_reg),
    .pick     (pick_onehot),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  logic in_grant, in_abort, limit, resp, accept, wd_fire;
  logic [IW-1:0] ptr_after;

  assign in_grant  = (state_reg == GRANT);
  assign in_abort  = (state_reg == ABORT);
  assign limit     = (outst_reg == OW'(MAX_OUTSTANDING));
  assign resp      = in_grant & (wbs_ack | wbs_err);
  assign accept    = wbs_stb & ~wbs_stall;
  assign ptr_after = (gidx_reg == IW'(NUM_MASTERS - 1)) ? '0 : gidx_reg + 1'b1;
  assign wd_fire   = (TIMEOUT_CYCLES != 0) && (outst_reg != '0) && !resp &&
                     (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Per-master views masked by the one-hot grant; OR-reduced below into the slave mux.
  logic [ADDR_WIDTH-1:0] adr_m [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_m [NUM_MASTERS];
  logic [SW-1:0]         sel_m [NUM_MASTERS];

  genvar gi;
  for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign adr_m[gi] = grant_reg[gi] ? wbm_adr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign dat_m[gi] = grant_reg[gi] ? wbm_dat_m[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign sel_m[gi] = grant_reg[gi] ? wbm_sel[gi*SW +: SW] : '0;

    assign wbm_stall[gi] = ~(grant_reg[gi] & in_grant) | wbs_stall | limit;
    assign wbm_ack[gi]   = grant_reg[gi] & in_grant & wbs_ack;
    assign wbm_err[gi]   = grant_reg[gi] & ((in_grant & wbs_err) | (in_abort & abort_first_reg));
  end

  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [SW-1:0]         sel_sel;

  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_adr = sel_adr | adr_m[i];
      sel_dat = sel_dat | dat_m[i];
      sel_sel = sel_sel | sel_m[i];
    end
  end

  logic sel_cyc, sel_stb, sel_we;
  assign sel_cyc = |(grant_reg & wbm_cyc);
  assign sel_stb = |(grant_reg & wbm_stb);
  assign sel_we  = |(grant_reg & wbm_we);

  assign wbs_cyc   = in_grant & sel_cyc;
  assign wbs_stb   = in_grant & sel_stb & ~limit;
  assign wbs_we    = in_grant & sel_we;
  assign wbs_adr   = in_grant ? sel_adr : '0;
  assign wbs_dat_m = in_grant ? sel_dat : '0;
  assign wbs_sel   = in_grant ? sel_sel : '0;
  assign wbm_dat_s = wbs_dat_s;
  assign grant     = grant_reg;
  assign timeout   = in_abort & abort_first_reg;

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    gidx_next        = gidx_reg;
    ptr_next         = ptr_reg;
    outst_next       = outst_reg;
    wdog_next        = wdog_reg;
    abort_first_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = pick_onehot;
          gidx_next  = pick_idx;
        end
      end
      GRANT: begin
        if (!sel_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
          outst_next = '0;
          wdog_next  = '0;
        end else if (wd_fire) begin
          state_next       = ABORT;
          abort_first_next = 1'b1;
          outst_next       = '0;
          wdog_next        = '0;
        end else begin
          // A response with nothing outstanding is forwarded but never counted.
          if (accept && !(resp && outst_reg != '0))
            outst_next = outst_reg + 1'b1;
          else if (!accept && resp && outst_reg != '0)
            outst_next = outst_reg - 1'b1;
          if (resp || outst_reg == '0 || TIMEOUT_CYCLES == 0)
            wdog_next = '0;
          else
            wdog_next = wdog_reg + 1'b1;
        end
      end
      ABORT: begin
        if (!sel_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      gidx_reg        <= '0;
      ptr_reg         <= '0;
      outst_reg       <= '0;
      wdog_reg        <= '0;
      abort_first_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      gidx_reg        <= gidx_next;
      ptr_reg         <= ptr_next;
      outst_reg       <= outst_next;
      wdog_reg        <= wdog_next;
      abort_first_reg <= abort_first_next;
    end
  end

endmodule
